systolic_drain_collector: RTL

- Result-side reader for the systolic array: once a compute pass finishes, it walks the array's drain select across all PEs and captures each PE's accumulator into a local buffer.
- It then streams the buffered results to the host side over a valid/ready handshake.
- Sits between the array's drain-select/accumulator-output pair and the output pins or a downstream serializer. It is the consumer of the drain path that the sequencing controller opens.

---
 rtl/systolic_drain_collector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/systolic_drain_collector.sv
// Walks drain_sel across NUM_PE PEs, buffers each accumulator, then streams the buffer out
// over valid/ready. Define DRAIN_CKSUM_EN to append a modular-sum checksum beat to each pass.
module systolic_drain_collector #(
   parameter int unsigned NUM_PE   = 4,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned READ_LAT = 1
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          drain_start,
   input  logic [DATA_W-1:0]                             acc_in,
   output logic [((NUM_PE > 1) ? $clog2(NUM_PE) : 1)-1:0] drain_sel,
   output logic [DATA_W-1:0]                             out_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic                                          out_last,
   output logic                                          busy,
   output logic                                          done
);

   localparam int unsigned SW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int unsigned CW = $clog2(NUM_PE + READ_LAT + 1);
   localparam logic [CW-1:0] SCAN_END = CW'(NUM_PE + READ_LAT - 1);
   localparam logic [CW-1:0] PE_MAX   = CW'(NUM_PE - 1);
   localparam logic [SW-1:0] SEL_MAX  = SW'(NUM_PE - 1);
`ifdef DRAIN_CKSUM_EN
   localparam logic [CW-1:0] LAST_IDX      = CW'(NUM_PE);
   localparam logic          FIRST_IS_LAST = 1'b0;
`else
   localparam logic [CW-1:0] LAST_IDX      = PE_MAX;
   localparam logic          FIRST_IS_LAST = (NUM_PE == 1);
`endif

   typedef enum logic [1:0] {StIdle, StScan, StSend} state_t;

   state_t            state;
   logic [CW-1:0]     scan_cnt;
   logic [CW-1:0]     cap_cnt;
   logic [CW-1:0]     idx;
   logic [DATA_W-1:0] res_buf [NUM_PE];
`ifdef DRAIN_CKSUM_EN
   logic [DATA_W-1:0] sum;
`endif

   logic [CW-1:0]     scan_nxt;
   logic [CW-1:0]     idx_nxt;
   logic [DATA_W-1:0] next_beat;
   logic              cap_en;

   assign scan_nxt = scan_cnt + CW'(1);
   assign idx_nxt  = idx + CW'(1);

   // Captures trail drain_sel by READ_LAT cycles.
   generate
      if (READ_LAT == 0) begin : g_cap_now
         assign cap_en = 1'b1;
      end else begin : g_cap_lat
         assign cap_en = (scan_cnt >= CW'(READ_LAT));
      end
   endgenerate

   always_comb begin
      next_beat = res_buf[idx_nxt[SW-1:0]];
`ifdef DRAIN_CKSUM_EN
      if (idx_nxt == CW'(NUM_PE)) next_beat = sum;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         scan_cnt  <= '0;
         cap_cnt   <= '0;
         idx       <= '0;
         drain_sel <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < NUM_PE; i++) res_buf[i] <= '0;
`ifdef DRAIN_CKSUM_EN
         sum       <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               // A start coinciding with done belongs to the pass that just ended.
               if (drain_start && !done) begin
                  state     <= StScan;
                  busy      <= 1'b1;
                  scan_cnt  <= '0;
                  cap_cnt   <= '0;
                  drain_sel <= '0;
`ifdef DRAIN_CKSUM_EN
                  sum       <= '0;
`endif
               end
            end
            StScan: begin
               if (cap_en) begin
                  res_buf[cap_cnt[SW-1:0]] <= acc_in;
                  cap_cnt                  <= cap_cnt + CW'(1);
`ifdef DRAIN_CKSUM_EN
                  sum                      <= sum + acc_in;
`endif
               end
               if (scan_cnt == SCAN_END) begin
                  state     <= StSend;
                  drain_sel <= '0;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  out_last  <= FIRST_IS_LAST;
                  // With one PE the first beat is the value being captured on this edge.
                  out_data  <= (cap_cnt == '0) ? acc_in : res_buf[0];
               end else begin
                  scan_cnt  <= scan_nxt;
                  drain_sel <= (scan_cnt < PE_MAX) ? scan_nxt[SW-1:0] : SEL_MAX;
               end
            end
            StSend: begin
               if (out_ready) begin
                  if (idx == LAST_IDX) begin
                     state     <= StIdle;
                     busy      <= 1'b0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     idx      <= idx_nxt;
                     out_data <= next_beat;
                     out_last <= (idx_nxt == LAST_IDX);
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
